// File: rtl/debounce_edge_pkg.sv
// Shared FSM state encodings and default qualification constants for the
// debounce stage.
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'b00,
        S_WAIT_HI = 2'b01,
        S_HIGH    = 2'b11,
        S_WAIT_LO = 2'b10
    } state_e;

    localparam int unsigned STABLE_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 4;

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input; usable by any
// block that needs to bring a raw level into its clock domain.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw asynchronous input: synchronises it, qualifies each level
// change over a stability window, and emits a clean level plus edge pulses.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE      = STABLE_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_in),
        .q   (s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The window closes when the advanced count reaches STABLE-1, so q moves
    // on edge SYNC_STAGES+STABLE-1 and the counter never reaches STABLE-1.
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                S_LOW: begin
                    if (s) begin
                        state_d = S_WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                S_WAIT_HI: begin
                    if (!s) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        state_d = S_WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                S_WAIT_LO: begin
                    if (s) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        q    = q_q;
        rise = rise_q;
        fall = fall_q;
        busy = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: run-length reference model checked every cycle,
// plus directed edge-count expectations for each scenario.
module tb_debounce_edge;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic d_in = 1'b0;
    logic q, rise, fall, busy;

    int tests = 0;
    int fails = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    debounce_edge #(
        .SYNC_STAGES(SYNC),
        .STABLE(STABLE),
        .CNT_W(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .d_in (d_in),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #20 clk = ~clk;

    // Reference: d_in delayed SYNC edges; q flips once the delayed level has
    // differed from q on STABLE-1 consecutive enabled edges.
    logic [SYNC-1:0] m_sync;
    logic m_q, m_rise, m_fall, s_old;
    int   m_run;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sync = '0;
            m_q    = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = 0;
        end else begin
            s_old  = m_sync[SYNC-1];
            m_sync = {m_sync[SYNC-2:0], d_in};
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (en) begin
                if (s_old != m_q) begin
                    m_run++;
                    if (m_run == STABLE - 1) begin
                        m_q    = ~m_q;
                        m_rise = m_q;
                        m_fall = ~m_q;
                        m_run  = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            check("q", int'(q), int'(m_q));
            check("rise", int'(rise), int'(m_rise));
            check("fall", int'(fall), int'(m_fall));
            check("busy", int'(busy), int'(m_run != 0));
            check("pulse_excl", int'(rise & fall), 0);
            check("pulse_gap", int'((rise | fall) & prev_pulse), 0);
            prev_pulse = rise | fall;
            if (rise) rise_seen++;
            if (fall) fall_seen++;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges from the next posedge until the requested pulse is seen.
    task automatic edges_to_pulse(input bit want_rise, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!(want_rise ? rise : fall) && n < 40);
    endtask

    task automatic reset_zero(input string name);
        check({name, "_q"}, int'(q), 0);
        check({name, "_rise"}, int'(rise), 0);
        check({name, "_fall"}, int'(fall), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    int n, r0, f0;

    initial begin
        // Reset hold with d_in already high
        d_in = 1'b1;
        #10 reset_zero("rst_hold_a");
        #15 reset_zero("rst_hold_b");
        #5 rst = 1'b1;
        edges_to_pulse(1'b1, n);
        check("rst_release_rise_edge", n, 9);
        check("rst_release_q", int'(q), 1);

        // Release
        idle(3);
        d_in = 1'b0;
        edges_to_pulse(1'b0, n);
        check("release_fall_edge", n, 9);
        check("release_q", int'(q), 0);

        // Clean press held 600 ns
        idle(3);
        f0 = fall_seen;
        r0 = rise_seen;
        d_in = 1'b1;
        edges_to_pulse(1'b1, n);
        check("press_rise_edge", n, 9);
        idle(6);
        check("press_q_held", int'(q), 1);
        check("press_one_rise", rise_seen - r0, 1);
        check("press_no_fall", fall_seen - f0, 0);
        d_in = 1'b0;
        idle(14);
        check("press_back_low", int'(q), 0);

        // Bounce: highs of 1/2/1/2/1 cycles separated by 2 low cycles
        r0 = rise_seen;
        f0 = fall_seen;
        for (int i = 0; i < 5; i++) begin
            d_in = 1'b1;
            idle((i % 2 == 0) ? 1 : 2);
            d_in = 1'b0;
            idle(2);
        end
        idle(12);
        check("bounce_q", int'(q), 0);
        check("bounce_no_rise", rise_seen - r0, 0);
        check("bounce_no_fall", fall_seen - f0, 0);

        // en freeze for 5 edges once the count has reached 4
        d_in = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 6) begin
                check("freeze_busy", int'(busy), 1);
                en = 1'b0;
            end
            if (n == 11) en = 1'b1;
        end while (!rise && n < 40);
        check("freeze_rise_edge", n, 14);
        d_in = 1'b0;
        idle(14);
        check("freeze_back_low", int'(q), 0);

        // Reset at count 5 while qualifying a rise
        d_in = 1'b1;
        idle(7);
        check("midrst_busy_before", int'(busy), 1);
        #5 rst = 1'b0;
        #1 reset_zero("midrst");
        #30 rst = 1'b1;
        edges_to_pulse(1'b1, n);
        check("midrst_rise_edge", n, 9);
        idle(3);
        check("midrst_q", int'(q), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
